// File: rtl/boron_mode_ctrl_if.sv
// Block stream interface for the boron mode controller: an input
// valid/ready channel carrying 64-bit blocks and a buffered output
// valid/ready channel carrying the processed blocks.
interface boron_mode_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        out_last;

  // Upstream producer / downstream consumer side
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  // Controller side
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/boron_mode_ctrl.sv
// Block-mode front end for the boron cipher core. Accepts one 64-bit
// block at a time, issues it to the core with ECB or CBC chaining,
// waits for the core's done (guarded by a saturating watchdog) and
// returns the result through a registered valid/ready output.
module boron_mode_ctrl #(
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int CNT_W          = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_cfg_mode,
  input  logic                    i_cfg_enc_dec,
  input  logic [79:0]             i_cfg_key,
  input  logic [63:0]             i_cfg_iv,
  boron_mode_ctrl_if.slave        io_bus,
  output logic                    o_core_start,
  output logic                    o_core_enc_dec,
  output logic [79:0]             o_core_key,
  output logic [63:0]             o_core_text,
  input  logic                    i_core_done,
  input  logic [63:0]             i_core_result,
  output logic                    o_err_timeout
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_OUT
  } state_t;

  localparam logic [CNT_W-1:0] LP_TIMEOUT = CNT_W'(TIMEOUT_CYCLES);

  state_t             r_state;
  logic               r_inReady;
  logic               r_outValid;
  logic [63:0]        r_outData;
  logic               r_outLast;
  logic               r_coreStart;
  logic [63:0]        r_coreText;
  logic [79:0]        r_key;
  logic               r_dir;
  logic               r_mode;
  logic               r_errTimeout;
  logic [63:0]        r_chain;
  logic               r_firstFlag;
  logic [63:0]        r_data;
  logic               r_last;
  logic [CNT_W-1:0]   r_wdog;

  logic               w_mode;
  logic               w_dir;
  logic [63:0]        w_chain;
  logic [63:0]        w_issueText;
  logic [63:0]        w_result;
  logic [CNT_W-1:0]   w_wdogNext;
  logic               w_timeout;
  logic               w_inFire;
  logic               w_outFire;

  // On the first block of a message the live configuration is used,
  // since the latched copy only becomes valid at the capture edge.
  assign w_mode  = r_firstFlag ? i_cfg_mode    : r_mode;
  assign w_dir   = r_firstFlag ? i_cfg_enc_dec : r_dir;
  assign w_chain = r_firstFlag ? i_cfg_iv      : r_chain;

  // Only CBC encryption mixes the chain in before the core.
  assign w_issueText = (w_mode && w_dir) ? (io_bus.in_data ^ w_chain) : io_bus.in_data;

  // Only CBC decryption mixes the chain in after the core.
  assign w_result = (r_mode && !r_dir) ? (i_core_result ^ r_chain) : i_core_result;

  assign w_wdogNext = (r_wdog == LP_TIMEOUT) ? r_wdog : (r_wdog + CNT_W'(1));
  assign w_timeout  = (w_wdogNext == LP_TIMEOUT);

  assign w_inFire  = io_bus.in_valid && r_inReady;
  assign w_outFire = r_outValid && io_bus.out_ready;

  assign io_bus.in_ready  = r_inReady;
  assign io_bus.out_valid = r_outValid;
  assign io_bus.out_data  = r_outData;
  assign io_bus.out_last  = r_outLast;
  assign o_core_start     = r_coreStart;
  assign o_core_text      = r_coreText;
  assign o_core_key       = r_key;
  assign o_core_enc_dec   = r_dir;
  assign o_err_timeout    = r_errTimeout;

  // Single FSM owning every register; all outputs are registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_inReady    <= 1'b0;
      r_outValid   <= 1'b0;
      r_outData    <= '0;
      r_outLast    <= 1'b0;
      r_coreStart  <= 1'b0;
      r_coreText   <= '0;
      r_key        <= '0;
      r_dir        <= 1'b0;
      r_mode       <= 1'b0;
      r_errTimeout <= 1'b0;
      r_chain      <= '0;
      r_firstFlag  <= 1'b1;
      r_data       <= '0;
      r_last       <= 1'b0;
      r_wdog       <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_inReady <= 1'b1;
          if (w_inFire) begin
            r_inReady   <= 1'b0;
            r_data      <= io_bus.in_data;
            r_last      <= io_bus.in_last;
            r_coreText  <= w_issueText;
            r_coreStart <= 1'b1;
            if (r_firstFlag) begin
              r_mode       <= i_cfg_mode;
              r_dir        <= i_cfg_enc_dec;
              r_key        <= i_cfg_key;
              r_chain      <= i_cfg_iv;
              r_errTimeout <= 1'b0;
              r_firstFlag  <= 1'b0;
            end
            r_state <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          r_coreStart <= 1'b0;
          r_wdog      <= '0;
          r_state     <= ST_WAIT;
        end

        ST_WAIT: begin
          if (i_core_done) begin
            r_outData  <= w_result;
            r_outValid <= 1'b1;
            r_outLast  <= r_last;
            if (r_mode) begin
              r_chain <= r_dir ? i_core_result : r_data;
            end
            r_state <= ST_OUT;
          end else if (w_timeout) begin
            r_errTimeout <= 1'b1;
            r_firstFlag  <= 1'b1;
            r_wdog       <= w_wdogNext;
            r_inReady    <= 1'b1;
            r_state      <= ST_IDLE;
          end else begin
            r_wdog <= w_wdogNext;
          end
        end

        ST_OUT: begin
          if (w_outFire) begin
            r_outValid <= 1'b0;
            if (r_outLast) begin
              r_firstFlag <= 1'b1;
              r_chain     <= '0;
            end
            r_inReady <= 1'b1;
            r_state   <= ST_IDLE;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/boron_mode_ctrl.md
Name: boron_mode_ctrl

Overview:
- Block-mode front end for the boron cipher core. Sits directly upstream: it accepts a stream of 64-bit blocks over a valid/ready interface and drives the core's plainText, masterKey, enc_dec and start inputs.
- It waits for the core's done, applies ECB or CBC chaining, and returns results on a buffered valid/ready output.
- One block is in flight at a time. A watchdog flags a core that never completes.

Parameters:
- TIMEOUT_CYCLES, 1023: maximum cycles spent waiting for core_done before an error is raised.
- CNT_W, 10: width of the watchdog counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cfg_mode  in  1  0=ECB, 1=CBC; latched on the first block of a message
- cfg_enc_dec  in  1  1=encrypt, 0=decrypt; latched on the first block
- cfg_key  in  80  master key; latched on the first block
- cfg_iv  in  64  CBC IV; latched on the first block
- in_valid  in  1  input block valid
- in_ready  out  1  controller can accept a block
- in_data  in  64  input block (plaintext or ciphertext)
- in_last  in  1  marks the final block of a message
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  64  result block
- out_last  out  1  copy of in_last for this block
- core_start  out  1  one-cycle start pulse to the core
- core_enc_dec  out  1  direction to the core
- core_key  out  80  masterKey to the core
- core_text  out  64  plainText input to the core
- core_done  in  1  core completion
- core_result  in  64  core cipherText output
- err_timeout  out  1  sticky timeout flag

Behaviour:
- Reset values:
  - in_ready=0 during reset, then 1 in IDLE.
  - out_valid=0, out_data=0, out_last=0, core_start=0, core_text=0, core_key=0, core_enc_dec=0, err_timeout=0.
  - Chain register=0, first_flag=1, watchdog=0.
- States: IDLE, ISSUE, WAIT, OUT.
- IDLE:
  - in_ready=1.
  - On in_valid: capture in_data and in_last.
  - If first_flag=1, latch cfg_* into mode, dir, key and chain (chain<=cfg_iv), clear err_timeout, then set first_flag=0.
  - Go to ISSUE.
- ISSUE: one cycle; core_start=1.
  - core_text = ECB: in_data.
  - core_text = CBC encrypt: in_data XOR chain.
  - core_text = CBC decrypt: in_data.
  - Go to WAIT with watchdog<=0.
- WAIT: core_start=0; core_text, core_key and core_enc_dec are held stable.
  - On the first cycle with core_done=1, compute the result:
    - ECB: core_result.
    - CBC encrypt: core_result; chain<=core_result.
    - CBC decrypt: core_result XOR chain; chain<=captured in_data.
  - Register the result into out_data, set out_valid=1, out_last=captured last, and go to OUT.
  - If the watchdog reaches TIMEOUT_CYCLES without done: set err_timeout=1, set first_flag=1, and return to IDLE. No output is produced and the block is dropped.
- OUT: hold out_valid, out_data and out_last until out_ready=1. On the handshake:
  - Clear out_valid.
  - If out_last=1, set first_flag=1 and chain<=0.
  - Go to IDLE.
- Latency: from in_valid&in_ready to out_valid = core latency + 3 cycles (IDLE capture, ISSUE, WAIT done-sample/register).
- core_done is ignored outside WAIT. A done asserted in the same cycle as ISSUE is not sampled.
- Simultaneous done and watchdog expiry: done wins.
- out_ready held low: the state stays in OUT indefinitely, in_ready=0, and no new core_start is issued.
- Reset mid-operation: all state returns to reset values the next cycle, including dropping any in-flight or buffered output. The core is not aborted; a stale core_done after reset is ignored because the FSM is in IDLE.
- cfg_* changes during a message have no effect until the block after the in_last handshake.
- The watchdog saturates and never wraps.

Test Plan:
The bench uses a stub core with done N cycles after start:
- Encrypt: result = text XOR key[63:0].
- Decrypt: result = text XOR key[63:0].

Scenarios (key[63:0]=64'h0F0F_0F0F_0F0F_0F0F unless noted):
- ECB encrypt, N=4: single block in_data=64'h0123_4567_89AB_CDEF, in_last=1 -> out_data=64'h0E2C_4A68_86A4_C2E0, out_last=1, out_valid exactly 7 cycles after the input handshake, exactly one core_start pulse.
- CBC encrypt, 2 blocks, IV=64'h1111_1111_1111_1111, P0=P1=0, key[63:0]=0 -> C0=64'h1111_1111_1111_1111, C1=64'h1111_1111_1111_1111. Then a new message with IV=0 and P0=5 -> C0=5, proving the chain resets after in_last.
- CBC decrypt round trip: feed C0 and C1 from the previous scenario with the same IV and key -> P0=P1=0 recovered.
- Backpressure: out_ready=0 for 20 cycles in OUT -> out_data is stable, in_ready=0, no core_start. Releasing out_ready completes the transfer and in_ready=1 the next cycle.
- Timeout: TIMEOUT_CYCLES=16, stub never asserts done -> err_timeout=1 after 16 WAIT cycles, no out_valid, FSM back in IDLE. The next message clears err_timeout on its first block.
- Reset asserted in WAIT: outputs return to reset values. A late core_done from the stub is ignored, and the next block uses a fresh IV.
